// File: rtl/q_pulse_meter.sv
// Pulse-width meter for the asynchronous mylogic output q: samples q, times each high
// pulse in clk cycles and presents results on a valid/ready register. Option macro: Q_SYNC_EN.
module q_pulse_meter #(
  parameter int WIDTH_W = 8,
  parameter int COUNT_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_q,
  input  logic               i_clear,
  input  logic               i_meas_ready,
  output logic               o_meas_valid,
  output logic [WIDTH_W-1:0] o_meas_width,
  output logic               o_meas_ovf,
  output logic [COUNT_W-1:0] o_pulse_count,
  output logic               o_dropped,
  output logic               o_pulse_active
);

`ifdef Q_SYNC_EN
  localparam int SYNC_DEPTH = 2;
`else
  localparam int SYNC_DEPTH = 1;
`endif

  localparam logic [WIDTH_W-1:0] W_MAX = {WIDTH_W{1'b1}};
  localparam logic [WIDTH_W-1:0] W_ONE = WIDTH_W'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HIGH = 1'b1
  } state_t;

  logic [SYNC_DEPTH-1:0] r_sync;
  logic                  w_q_s;

  state_t                r_state;
  state_t                w_state_next;

  logic [WIDTH_W-1:0]    r_cnt;
  logic [WIDTH_W-1:0]    w_cnt_next;
  logic                  r_ovf;
  logic                  w_ovf_next;

  logic                  r_meas_valid;
  logic [WIDTH_W-1:0]    r_meas_width;
  logic                  r_meas_ovf;
  logic [COUNT_W-1:0]    r_pulse_count;
  logic                  r_dropped;

  logic                  w_pulse_start;
  logic                  w_pulse_high;
  logic                  w_pulse_end;
  logic                  w_out_free;
  logic                  w_load;
  logic                  w_drop;
  logic                  w_pulse_active;

  // Sampler chain; the last flop is the q_s that the FSM observes.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_DEPTH; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge i_clk or posedge i_rst) begin
          if (i_rst) r_sync[gi] <= 1'b0;
          else       r_sync[gi] <= i_q;
        end
      end else begin : g_next
        always_ff @(posedge i_clk or posedge i_rst) begin
          if (i_rst) r_sync[gi] <= 1'b0;
          else       r_sync[gi] <= r_sync[gi-1];
        end
      end
    end
  endgenerate

  assign w_q_s = r_sync[SYNC_DEPTH-1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_q_s)  w_state_next = S_HIGH;
      S_HIGH:  if (!w_q_s) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_pulse_active = (r_state == S_HIGH);
  end

  assign w_pulse_start = (r_state == S_IDLE) && w_q_s;
  assign w_pulse_high  = (r_state == S_HIGH) && w_q_s;
  assign w_pulse_end   = (r_state == S_HIGH) && !w_q_s;

  // The overflow flag rises as soon as the counter reaches all-ones, so a pulse of
  // exactly 2^WIDTH_W-1 cycles already reports saturation.
  always_comb begin
    w_cnt_next = r_cnt;
    w_ovf_next = r_ovf;
    if (w_pulse_start) begin
      w_cnt_next = W_ONE;
      w_ovf_next = (W_ONE == W_MAX);
    end else if (w_pulse_high) begin
      if (r_cnt != W_MAX) w_cnt_next = r_cnt + W_ONE;
      w_ovf_next = r_ovf || (w_cnt_next == W_MAX);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      r_ovf <= w_ovf_next;
    end
  end

  assign w_out_free = !r_meas_valid || i_meas_ready;
  assign w_load     = w_pulse_end && w_out_free;
  assign w_drop     = w_pulse_end && !w_out_free;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meas_valid <= 1'b0;
      r_meas_width <= '0;
      r_meas_ovf   <= 1'b0;
    end else if (w_load) begin
      r_meas_valid <= 1'b1;
      r_meas_width <= r_cnt;
      r_meas_ovf   <= r_ovf;
    end else if (r_meas_valid && i_meas_ready) begin
      r_meas_valid <= 1'b0;
    end
  end

  // Clear takes priority over a same-cycle increment or drop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pulse_count <= '0;
      r_dropped     <= 1'b0;
    end else if (i_clear) begin
      r_pulse_count <= '0;
      r_dropped     <= 1'b0;
    end else begin
      if (w_pulse_end) r_pulse_count <= r_pulse_count + COUNT_W'(1);
      if (w_drop)      r_dropped     <= 1'b1;
    end
  end

  assign o_meas_valid   = r_meas_valid;
  assign o_meas_width   = r_meas_width;
  assign o_meas_ovf     = r_meas_ovf;
  assign o_pulse_count  = r_pulse_count;
  assign o_dropped      = r_dropped;
  assign o_pulse_active = w_pulse_active;

endmodule

// File: doc/q_pulse_meter.md
# q_pulse_meter

Downstream measurement stage for the `mylogic` output `q`. It samples `q` into the clock domain and measures the width of every high pulse in clock cycles. Each result is presented on a valid/ready output register, and the block keeps a running pulse count. It sits directly after `mylogic` and turns its asynchronous output into checkable, time-stamped data for the bench and for later stages.

## Interface
- `WIDTH_W`, default 8: pulse-width counter and `meas_width` width.
- `COUNT_W`, default 8: `pulse_count` width.

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `q`, input, 1: `mylogic` output; asynchronous to `clk`.
- `clear`, input, 1: synchronous clear of `pulse_count` and `dropped`.
- `meas_ready`, input, 1: consumer accepts the measurement.
- `meas_valid`, output, 1: a measurement is held.
- `meas_width`, output, WIDTH_W: width of the pulse, in sampled-high cycles.
- `meas_ovf`, output, 1: width saturated.
- `pulse_count`, output, COUNT_W: completed pulses, modulo 2^COUNT_W.
- `dropped`, output, 1: sticky; set when a measurement was lost because the output register was full.
- `pulse_active`, output, 1: FSM is in HIGH.

## Operation
- Sampler: `q_s` is the registered sample of `q`; its depth is set by the macro in Configuration.
- FSM IDLE:
  - `q_s`=1 → HIGH; width counter := 1, overflow flag := 0.
- FSM HIGH while `q_s`=1:
  - Counter increments.
  - At all-ones it holds and sets the overflow flag.
- FSM HIGH when `q_s`=0 (pulse end) → IDLE:
  - `pulse_count` += 1, wrapping.
  - If the output register is free, load it. Free means `meas_valid`=0, or `meas_valid`&`meas_ready` this cycle.
  - Loading sets `meas_width` := counter, `meas_ovf` := overflow flag, `meas_valid` := 1.
  - Otherwise the output register is unchanged and `dropped` := 1.
- Handshake:
  - Transfer occurs on an edge where `meas_valid`&`meas_ready`=1.
  - `meas_width` and `meas_ovf` stay stable while `meas_valid`&!`meas_ready`.
  - After a transfer, `meas_valid` falls, unless a new load occurs the same cycle; then it stays 1 with the new data.
- `clear`: `pulse_count` := 0 and `dropped` := 0.
  - `clear` wins over a simultaneous increment or drop.
  - A simultaneous load still occurs.
- `pulse_active` = (state == HIGH).

## Timing
- Reset values:
  - State IDLE; sampler flops 0; counter 0.
  - `meas_valid` 0, `meas_width` 0, `meas_ovf` 0, `pulse_count` 0, `dropped` 0, `pulse_active` 0.
- Width: equals the number of rising `clk` edges at which `q` was sampled high. Glitches shorter than one period may be missed.
- Latency from a `q` fall to `meas_valid`=1:
  - 3 edges with `Q_SYNC_EN`; 2 edges without.
  - Rise-to-`pulse_active` latency is the same.
- A one-cycle low gap between pulses is resolved as two separate pulses; IDLE lasts exactly one cycle.
- Reset mid-pulse:
  - The measurement is discarded.
  - If `q` is still high after release, only the remaining sampled-high cycles are measured.
- Saturation: `meas_width` = 2^WIDTH_W−1 with `meas_ovf`=1 for any pulse of at least 2^WIDTH_W−1 cycles.
- Count wrap: all-ones + 1 → 0; no flag.

## Configuration
- `Q_SYNC_EN` defined:
  - `q` passes through a two-flop synchronizer, and `q_s` is the second flop.
  - Safe for a truly asynchronous `q`.
- Not defined:
  - `q_s` is a single register of `q`.
  - All latencies are one edge shorter; widths are identical.

## Test plan
- `rst`=1 with `q`=1 and `meas_ready`=1 → all outputs at reset values. Release with `q` held high 3 edges then low → `meas_width`=3, `pulse_count`=1.
- `q` high for 5 edges, `meas_ready`=1, `Q_SYNC_EN` → `meas_valid` high for 1 cycle, 3 edges after the `q` fall. `meas_width`=5, `meas_ovf`=0, `pulse_count`=1.
- WIDTH_W=4, `q` high 20 edges → `meas_width`=15, `meas_ovf`=1.
- `meas_ready`=0, pulses of 3 and then 4 → `meas_width` holds 3, `dropped`=1, `pulse_count`=2. Then `meas_ready`=1 → one transfer and `meas_valid`=0. Then `clear` → `pulse_count`=0, `dropped`=0.
- Pulse 2, gap of 1 cycle, pulse 3, `meas_ready`=1 → measurements 2 then 3, `pulse_count`=2, no drop.
- COUNT_W=2, five pulses → `pulse_count` reads 1, 2, 3, 0, 1.
